// File: rtl/prog_sequencer_pkg.sv
// Shared types for the program-run sequencer: PC commands, FSM states and counter widths.
package prog_sequencer_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    INC   = 3'd1,
    BR_UP = 3'd2,
    BR_DN = 3'd3,
    LOAD  = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned OFF_W = 8;

endpackage

// File: rtl/prog_sequencer_if.sv
// Control bundle between decoder/ALU flags, the sequencer and the PC register.
interface prog_sequencer_if #(
  parameter int unsigned L = 10
);
  import prog_sequencer_pkg::*;

  logic             Start;
  logic [L-1:0]     Pc;
  logic             Halt;
  logic             StallReq;
  logic             BranchEn;
  logic             BranchDir;
  logic             BranchTaken;
  logic [OFF_W-1:0] BranchOff;

  pc_sel_e          PcSel;
  logic [L-1:0]     LoadAddr;
  logic [1:0]       ProgIdx;
  logic             Running;
  logic             Done;
  logic             Fault;
  logic [CNT_W-1:0] CycleCount;

  modport master (
    output Start, Pc, Halt, StallReq, BranchEn, BranchDir, BranchTaken, BranchOff,
    input  PcSel, LoadAddr, ProgIdx, Running, Done, Fault, CycleCount
  );

  modport slave (
    input  Start, Pc, Halt, StallReq, BranchEn, BranchDir, BranchTaken, BranchOff,
    output PcSel, LoadAddr, ProgIdx, Running, Done, Fault, CycleCount
  );

endinterface

// File: rtl/prog_sequencer_watchdog.sv
// Saturating RUN-cycle counter; expire_o flags the last permitted cycle while enabled.
module seq_watchdog
  import prog_sequencer_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] LIMIT = MAX_CYCLES - CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = en_i && (count_q == LIMIT);

endmodule

// File: rtl/prog_sequencer.sv
// Run-control FSM: turns Start/Halt/Stall/branch inputs into one PC command per cycle
// and rotates through the program start addresses.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned                  L           = 10,
  parameter int unsigned                  NUM_PROGS   = 3,
  parameter logic [NUM_PROGS-1:0][L-1:0]  START_ADDRS = '0,
  parameter logic [CNT_W-1:0]             MAX_CYCLES  = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  prog_sequencer_if.slave   bus
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             fault_q, fault_d;
  pc_sel_e          pc_sel;
  logic [L-1:0]     load_addr;

  logic             wd_clear;
  logic             wd_en;
  logic             wd_expire;
  logic [CNT_W-1:0] cycles;

  logic [L:0]       off_ext;
  logic [L:0]       fwd_sum;
  logic             br_fault;

  // One extra bit catches forward overflow; backward underflow is Off > Pc.
  assign off_ext  = (L+1)'(bus.BranchOff);
  assign fwd_sum  = {1'b0, bus.Pc} + off_ext;
  assign br_fault = bus.BranchDir ? (off_ext > {1'b0, bus.Pc}) : fwd_sum[L];

  always_comb begin
    load_addr = START_ADDRS[0];
    for (int unsigned i = 1; i < NUM_PROGS; i++) begin
      if (32'(idx_q) == i) load_addr = START_ADDRS[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fault_d = fault_q;
    pc_sel  = HOLD;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) state_d = ARMED;
      end
      ARMED: begin
        pc_sel = LOAD;
        if (!bus.Start) state_d = RUN;
      end
      RUN: begin
        if (bus.Start) begin
          pc_sel  = LOAD;
          state_d = ARMED;
          fault_d = 1'b0;
        end else if (bus.Halt) begin
          state_d = DONE;
          idx_d   = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
        end else if (wd_expire) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else if (bus.StallReq) begin
          pc_sel = HOLD;
        end else if (bus.BranchEn && bus.BranchTaken) begin
          if (br_fault) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else begin
            pc_sel = bus.BranchDir ? BR_UP : BR_DN;
          end
        end else begin
          pc_sel = INC;
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d = ARMED;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fault_q <= fault_d;
    end
  end

  // Clearing on the transition makes CycleCount read zero in the first ARMED cycle.
  assign wd_clear = (state_d == ARMED);
  assign wd_en    = (state_q == RUN);

  seq_watchdog #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear_i  (wd_clear),
    .en_i     (wd_en),
    .count_o  (cycles),
    .expire_o (wd_expire)
  );

  assign bus.PcSel      = pc_sel;
  assign bus.LoadAddr   = load_addr;
  assign bus.ProgIdx    = idx_q;
  assign bus.Running    = (state_q == RUN);
  assign bus.Done       = (state_q == DONE);
  assign bus.Fault      = fault_q;
  assign bus.CycleCount = cycles;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scenario bench for prog_sequencer: per-cycle stimulus rows with expected outputs queued and compared.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int unsigned L = 10;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  prog_sequencer_if #(.L(L)) bus ();

  prog_sequencer #(
    .L           (L),
    .NUM_PROGS   (3),
    .START_ADDRS ({10'd300, 10'd200, 10'd100}),
    .MAX_CYCLES  (16'd8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  sel;
    logic [9:0]  addr;
    logic [1:0]  idx;
    logic        run;
    logic        done;
    logic        fault;
    logic [15:0] cc;
  } obs_t;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    int         pc;
    int         off;
    obs_t       e;
  } row_t;

  localparam logic [6:0] RS = 7'h40, S = 7'h20, H = 7'h10, ST = 7'h08;
  localparam logic [6:0] BE = 7'h04, BD = 7'h02, BT = 7'h01, NO = 7'h00;

  logic [9:0] addr_tab [3] = '{10'd100, 10'd200, 10'd300};

  obs_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic row_t R(string tag, logic [6:0] ctl, int pc, int off, pc_sel_e sel,
                             int idx, bit run, bit done, bit fault, int cc);
    row_t r;
    r.tag     = tag;
    r.ctl     = ctl;
    r.pc      = pc;
    r.off     = off;
    r.e.sel   = sel;
    r.e.addr  = addr_tab[idx];
    r.e.idx   = 2'(idx);
    r.e.run   = run;
    r.e.done  = done;
    r.e.fault = fault;
    r.e.cc    = 16'(cc);
    return r;
  endfunction

  task automatic drive(input row_t r);
    Reset           = r.ctl[6];
    bus.Start       = r.ctl[5];
    bus.Halt        = r.ctl[4];
    bus.StallReq    = r.ctl[3];
    bus.BranchEn    = r.ctl[2];
    bus.BranchDir   = r.ctl[1];
    bus.BranchTaken = r.ctl[0];
    bus.Pc          = 10'(r.pc);
    bus.BranchOff   = 8'(r.off);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.sel   = bus.PcSel;
    o.addr  = bus.LoadAddr;
    o.idx   = bus.ProgIdx;
    o.run   = bus.Running;
    o.done  = bus.Done;
    o.fault = bus.Fault;
    o.cc    = bus.CycleCount;
    return o;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(R("reset", RS, 0, 0, HOLD, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_start();
    row_t rows[$];
    rows.push_back(R("idle_start", S,  0, 0, HOLD, 0, 0, 0, 0, 0));
    rows.push_back(R("armed_1",    S,  0, 0, LOAD, 0, 0, 0, 0, 0));
    rows.push_back(R("armed_2",    S,  0, 0, LOAD, 0, 0, 0, 0, 0));
    rows.push_back(R("release",    NO, 0, 0, LOAD, 0, 0, 0, 0, 0));
    rows.push_back(R("run_inc0",   NO, 0, 0, INC,  0, 1, 0, 0, 0));
    rows.push_back(R("run_inc1",   NO, 0, 0, INC,  0, 1, 0, 0, 1));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_branch_back();
    row_t rows[$];
    rows.push_back(R("bup_off5",    BE|BD|BT, 20, 5,  BR_UP, 0, 1, 0, 0, 2));
    rows.push_back(R("bup_off_pc",  BE|BD|BT, 20, 20, BR_UP, 0, 1, 0, 0, 3));
    rows.push_back(R("bup_range",   BE|BD|BT, 20, 21, HOLD,  0, 1, 0, 0, 4));
    rows.push_back(R("bup_faulted", NO, 0, 0, HOLD, 0, 0, 1, 1, 5));
    rows.push_back(R("rearm",       S,  0, 0, HOLD, 0, 0, 1, 1, 5));
    rows.push_back(R("reload",      NO, 0, 0, LOAD, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_branch_fwd();
    row_t rows[$];
    rows.push_back(R("bdn_off3",    BE|BT, 1020, 3, BR_DN, 0, 1, 0, 0, 0));
    rows.push_back(R("bdn_range",   BE|BT, 1020, 4, HOLD,  0, 1, 0, 0, 1));
    rows.push_back(R("bdn_faulted", NO, 0, 0, HOLD, 0, 0, 1, 1, 2));
    rows.push_back(R("rearm",       S,  0, 0, HOLD, 0, 0, 1, 1, 2));
    rows.push_back(R("reload",      NO, 0, 0, LOAD, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    rows.push_back(R("halt_wins", H|ST|BE|BT, 1020, 4, HOLD, 0, 1, 0, 0, 0));
    rows.push_back(R("halt_done", NO, 0, 0, HOLD, 1, 0, 1, 0, 1));
    rows.push_back(R("arm_p1",    S,  0, 0, HOLD, 1, 0, 1, 0, 1));
    rows.push_back(R("load_p1",   NO, 0, 0, LOAD, 1, 0, 0, 0, 0));
    rows.push_back(R("halt_p1",   H,  0, 0, HOLD, 1, 1, 0, 0, 0));
    rows.push_back(R("arm_p2",    S,  0, 0, HOLD, 2, 0, 1, 0, 1));
    rows.push_back(R("load_p2",   NO, 0, 0, LOAD, 2, 0, 0, 0, 0));
    rows.push_back(R("halt_p2",   H,  0, 0, HOLD, 2, 1, 0, 0, 0));
    rows.push_back(R("wrap_p0",   NO, 0, 0, HOLD, 0, 0, 1, 0, 1));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    rows.push_back(R("arm",  S,  0, 0, HOLD, 0, 0, 1, 0, 1));
    rows.push_back(R("load", NO, 0, 0, LOAD, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      rows.push_back(R("stall", ST|BE|BT, 20, 5, HOLD, 0, 1, 0, 0, i));
    rows.push_back(R("not_taken", BE, 20, 5, INC, 0, 1, 0, 0, 4));
    rows.push_back(R("inc",       NO, 0,  0, INC, 0, 1, 0, 0, 5));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_watchdog();
    row_t rows[$];
    rows.push_back(R("abort_run", S,  0, 0, LOAD, 0, 1, 0, 0, 6));
    rows.push_back(R("load",      NO, 0, 0, LOAD, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++)
      rows.push_back(R("run", NO, 0, 0, INC, 0, 1, 0, 0, i));
    rows.push_back(R("wd_expire", NO, 0, 0, HOLD, 0, 1, 0, 0, 7));
    rows.push_back(R("wd_done",   NO, 0, 0, HOLD, 0, 0, 1, 1, 8));
    rows.push_back(R("wd_hold",   NO, 0, 0, HOLD, 0, 0, 1, 1, 8));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(R("arm",     S,  0, 0, HOLD, 0, 0, 1, 1, 8));
    rows.push_back(R("load",    NO, 0, 0, LOAD, 0, 0, 0, 0, 0));
    rows.push_back(R("halt",    H,  0, 0, HOLD, 0, 1, 0, 0, 0));
    rows.push_back(R("arm_p1",  S,  0, 0, HOLD, 1, 0, 1, 0, 1));
    rows.push_back(R("load_p1", NO, 0, 0, LOAD, 1, 0, 0, 0, 0));
    rows.push_back(R("run0",    NO, 0, 0, INC,  1, 1, 0, 0, 0));
    rows.push_back(R("run1",    NO, 0, 0, INC,  1, 1, 0, 0, 1));
    rows.push_back(R("abort",   S,  0, 0, LOAD, 1, 1, 0, 0, 2));
    rows.push_back(R("held0",   S,  0, 0, LOAD, 1, 0, 0, 0, 0));
    rows.push_back(R("held1",   S,  0, 0, LOAD, 1, 0, 0, 0, 0));
    rows.push_back(R("release", NO, 0, 0, LOAD, 1, 0, 0, 0, 0));
    rows.push_back(R("rerun",   NO, 0, 0, INC,  1, 1, 0, 0, 0));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    rows.push_back(R("reset_mid",   RS|ST, 0, 0, HOLD, 1, 1, 0, 0, 1));
    rows.push_back(R("after_reset", NO,    0, 0, HOLD, 0, 0, 0, 0, 0));
    foreach (rows[k]) begin
      obs_t got, want;
      drive(rows[k]);
      sb.push_back(rows[k].e);
      #1 got = sample();
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %p, expected %p", rows[k].tag, got, want);
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset           = 1'b1;
    bus.Start       = 1'b0;
    bus.Halt        = 1'b0;
    bus.StallReq    = 1'b0;
    bus.BranchEn    = 1'b0;
    bus.BranchDir   = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.Pc          = '0;
    bus.BranchOff   = '0;
    @(negedge Clk);
    test_reset();
    test_start();
    test_branch_back();
    test_branch_fwd();
    test_halt();
    test_stall();
    test_watchdog();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
